// File: rtl/sniffer_pkg.sv
// Shared types and constants for the sniffer hit writer: record header magic,
// writer FSM states and hit-source indices.
package sniffer_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } hw_state_t;

  localparam int unsigned SRC_PORT = 0;
  localparam int unsigned SRC_IP   = 1;
  localparam int unsigned SRC_MAC  = 2;
  localparam int unsigned SRC_URL  = 3;

endpackage

// File: rtl/sniffer_hit_writer_rr_arbiter.sv
// Round-robin arbiter: searches upward from the source after the last winner;
// the pointer moves only when advance is strobed.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  int unsigned      cand;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_grant) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
    if (found) grant[idx] = 1'b1;
  end

  // Pointer starts on the last source so source 0 wins the first search.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) last_grant <= IDX_W'(NUM_REQ - 1);
    else if (advance) last_grant <= idx;
  end

endmodule

// File: rtl/sniffer_hit_writer.sv
// Shares one Avalon-MM write master between the hit sources, writing each hit
// as a header + data record into an SDRAM ring drained by software.
module sniffer_hit_writer
  import sniffer_pkg::*;
#(
  parameter  int unsigned       ADDR_W     = 26,
  parameter  int unsigned       DATA_W     = 32,
  parameter  int unsigned       NUM_REQ    = 4,
  parameter  logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter  int unsigned       RING_WORDS = 1024,
  localparam int unsigned       PTR_W      = $clog2(RING_WORDS),
  localparam int unsigned       IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        hit_valid,
  input  logic [NUM_REQ*DATA_W-1:0] hit_data,
  output logic [NUM_REQ-1:0]        hit_ready,
  input  logic [PTR_W-1:0]          sw_rd_ptr,
  output logic [PTR_W-1:0]          wr_ptr,
  output logic [ADDR_W-1:0]         master_address,
  output logic [DATA_W-1:0]         master_writedata,
  output logic                      master_write,
  input  logic                      master_waitrequest,
  output logic [15:0]               drop_count,
  output logic                      busy
);

  hw_state_t          state, state_nx;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_now;
  logic               room;
  logic [PTR_W-1:0]   used;
  logic [PTR_W-1:0]   free;
  logic [DATA_W-1:0]  data_q;
  logic [IDX_W-1:0]   src_q;
  logic [15:0]        seq;
  logic               accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .n_rst   (n_rst),
    .req     (hit_valid),
    .advance (grant_now),
    .grant   (grant),
    .idx     (grant_idx)
  );

  assign grant_now = (state == IDLE) && enable && (|hit_valid);
  assign used      = wr_ptr - sw_rd_ptr;
  assign free      = PTR_W'(RING_WORDS - 1) - used;
  assign room      = (free >= PTR_W'(2));
  assign accept    = (state != IDLE) && !master_waitrequest;

  // Gated by n_rst so a pending hit cannot see an accept pulse while in reset.
  assign hit_ready = (grant_now && n_rst) ? grant : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_now && room) state_nx = HDR;
      HDR:     if (!master_waitrequest) state_nx = DATA;
      DATA:    if (!master_waitrequest) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      seq        <= '0;
      drop_count <= '0;
      data_q     <= '0;
      src_q      <= '0;
    end else begin
      if (grant_now) begin
        data_q <= hit_data[grant_idx*DATA_W +: DATA_W];
        src_q  <= grant_idx;
        if (!room && (drop_count != '1)) drop_count <= drop_count + 16'd1;
      end
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (accept && (state == DATA)) seq <= seq + 16'd1;
    end
  end

  always_comb begin
    master_write     = (state != IDLE);
    busy             = (state != IDLE);
    master_address   = '0;
    master_writedata = '0;
    if (state != IDLE) master_address = BASE_ADDR + ADDR_W'({wr_ptr, 2'b00});
    case (state)
      HDR:     master_writedata = DATA_W'({HDR_MAGIC, 8'(src_q), seq});
      DATA:    master_writedata = data_q;
      default: master_writedata = '0;
    endcase
  end

endmodule

// File: tb/tb_sniffer_hit_writer.sv
// Scoreboard bench: stimulus pushes expected grants and bus writes, per-DUT
// monitors pop and compare on each accepted write / ready pulse.
module tb_sniffer_hit_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT A: default ring (1024 words)
  logic         rst_a = 1'b0, en_a = 1'b1, wr_a = 1'b0;
  logic [3:0]   hv_a = '0, hr_a;
  logic [127:0] hd_a = '0;
  logic [9:0]   sw_a = '0, wp_a;
  logic [25:0]  ma_a;
  logic [31:0]  md_a;
  logic         mw_a, busy_a;
  logic [15:0]  dc_a;

  // DUT B: 4-word ring
  logic         rst_b = 1'b0, en_b = 1'b1, wr_b = 1'b0;
  logic [3:0]   hv_b = '0, hr_b;
  logic [127:0] hd_b = '0;
  logic [1:0]   sw_b = '0, wp_b;
  logic [25:0]  ma_b;
  logic [31:0]  md_b;
  logic         mw_b, busy_b;
  logic [15:0]  dc_b;

  sniffer_hit_writer dut_a (
    .clk(clk), .n_rst(rst_a), .enable(en_a), .hit_valid(hv_a), .hit_data(hd_a),
    .hit_ready(hr_a), .sw_rd_ptr(sw_a), .wr_ptr(wp_a), .master_address(ma_a),
    .master_writedata(md_a), .master_write(mw_a), .master_waitrequest(wr_a),
    .drop_count(dc_a), .busy(busy_a)
  );

  sniffer_hit_writer #(.RING_WORDS(4)) dut_b (
    .clk(clk), .n_rst(rst_b), .enable(en_b), .hit_valid(hv_b), .hit_data(hd_b),
    .hit_ready(hr_b), .sw_rd_ptr(sw_b), .wr_ptr(wp_b), .master_address(ma_b),
    .master_writedata(md_b), .master_write(mw_b), .master_waitrequest(wr_b),
    .drop_count(dc_b), .busy(busy_b)
  );

  logic [57:0] qa[$], qb[$];
  logic [3:0]  qga[$], qgb[$];
  logic [57:0] ea, eb;
  logic [3:0]  ga, gb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hit_a(input int src, input logic [31:0] d);
    hd_a[src*32 +: 32] = d;
    hv_a[src] = 1'b1;
    cyc(1);
    hv_a[src] = 1'b0;
  endtask

  task automatic hit_b(input int src, input logic [31:0] d);
    hd_b[src*32 +: 32] = d;
    hv_b[src] = 1'b1;
    cyc(1);
    hv_b[src] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mw_a && !wr_a) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_write_unexpected: got %h/%h expected none", ma_a, md_a);
      end else begin
        ea = qa.pop_front();
        check("a_write", {6'b0, ma_a, md_a}, {6'b0, ea});
      end
    end
    if (hr_a != 4'b0) begin
      if (qga.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_grant_unexpected: got %b expected none", hr_a);
      end else begin
        ga = qga.pop_front();
        check("a_grant", {60'b0, hr_a}, {60'b0, ga});
      end
    end
  end

  always @(negedge clk) begin
    if (mw_b && !wr_b) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_write_unexpected: got %h/%h expected none", ma_b, md_b);
      end else begin
        eb = qb.pop_front();
        check("b_write", {6'b0, ma_b, md_b}, {6'b0, eb});
      end
    end
    if (hr_b != 4'b0) begin
      if (qgb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_grant_unexpected: got %b expected none", hr_b);
      end else begin
        gb = qgb.pop_front();
        check("b_grant", {60'b0, hr_b}, {60'b0, gb});
      end
    end
  end

  initial begin
    cyc(2);
    check("a_reset_wr_ptr", {54'b0, wp_a}, 64'd0);
    check("a_reset_write", {63'b0, mw_a}, 64'd0);
    check("a_reset_drop", {48'b0, dc_a}, 64'd0);
    check("a_reset_busy", {63'b0, busy_a}, 64'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    cyc(2);

    // single hit from mac source
    qga.push_back(4'b0100);
    qa.push_back({26'h0, 32'hA5020000});
    qa.push_back({26'h4, 32'h00112233});
    hit_a(2, 32'h00112233);
    check("a_single_busy", {63'b0, busy_a}, 64'd1);
    cyc(3);
    check("a_single_wr_ptr", {54'b0, wp_a}, 64'd2);
    check("a_single_drop", {48'b0, dc_a}, 64'd0);
    check("a_single_idle", {63'b0, busy_a}, 64'd0);

    // all sources valid, 8 grants from reset: order 0,1,2,3,... seq 0..7
    rst_a = 1'b0; cyc(1); rst_a = 1'b1; cyc(1);
    for (int k = 0; k < 8; k++) begin
      qga.push_back(4'b0001 << (k % 4));
      qa.push_back({26'(8 * k), 8'hA5, 8'(k % 4), 16'(k)});
      qa.push_back({26'(8 * k + 4), 32'hDA7A0000 | 32'(k % 4)});
    end
    for (int s = 0; s < 4; s++) hd_a[s*32 +: 32] = 32'hDA7A0000 | 32'(s);
    hv_a = 4'hF;
    cyc(22);
    hv_a = 4'h0;
    cyc(3);
    check("a_rr_wr_ptr", {54'b0, wp_a}, 64'd16);

    // header stalled by waitrequest: bus must hold steady
    wr_a = 1'b1;
    qga.push_back(4'b0010);
    qa.push_back({26'h40, 32'hA5010008});
    qa.push_back({26'h44, 32'hCAFEF00D});
    hit_a(1, 32'hCAFEF00D);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("a_stall_write", {63'b0, mw_a}, 64'd1);
      check("a_stall_addr_data", {6'b0, ma_a, md_a}, {6'b0, 26'h40, 32'hA5010008});
    end
    @(posedge clk); #1;
    wr_a = 1'b0;
    cyc(3);
    check("a_stall_wr_ptr", {54'b0, wp_a}, 64'd18);

    // enable drops mid-record: record completes, no further grant
    qga.push_back(4'b1000);
    qa.push_back({26'h48, 32'hA5030009});
    qa.push_back({26'h4C, 32'h0BADBEEF});
    hit_a(3, 32'h0BADBEEF);
    en_a = 1'b0;
    hv_a = 4'b0001;
    cyc(5);
    check("a_disable_busy", {63'b0, busy_a}, 64'd0);
    check("a_disable_wr_ptr", {54'b0, wp_a}, 64'd20);
    hv_a = 4'b0000;
    en_a = 1'b1;
    cyc(1);

    // 4-word ring: first record fits, second dropped (free=1)
    qgb.push_back(4'b0001);
    qb.push_back({26'h0, 32'hA5000000});
    qb.push_back({26'h4, 32'h11110000});
    hit_b(0, 32'h11110000);
    cyc(3);
    check("b_first_wr_ptr", {62'b0, wp_b}, 64'd2);
    qgb.push_back(4'b0010);
    hit_b(1, 32'h22220000);
    check("b_drop_busy", {63'b0, busy_b}, 64'd0);
    cyc(3);
    check("b_drop_count", {48'b0, dc_b}, 64'd1);
    check("b_drop_wr_ptr", {62'b0, wp_b}, 64'd2);

    // software frees space: record lands at words 2,3 and pointer wraps
    sw_b = 2'd2;
    qgb.push_back(4'b0100);
    qb.push_back({26'h8, 32'hA5020001});
    qb.push_back({26'hC, 32'h33330000});
    hit_b(2, 32'h33330000);
    cyc(3);
    check("b_wrap_wr_ptr", {62'b0, wp_b}, 64'd0);
    sw_b = 2'd0;
    qgb.push_back(4'b1000);
    qb.push_back({26'h0, 32'hA5030002});
    qb.push_back({26'h4, 32'h44440000});
    hit_b(3, 32'h44440000);
    cyc(3);
    check("b_third_wr_ptr", {62'b0, wp_b}, 64'd2);
    check("b_third_drop", {48'b0, dc_b}, 64'd1);

    // reset while DATA is stalled
    sw_b = 2'd2;
    qgb.push_back(4'b1000);
    qb.push_back({26'h8, 32'hA5030003});
    hit_b(3, 32'h55550000);
    cyc(1);
    wr_b = 1'b1;
    @(negedge clk);
    check("b_data_stalled", {63'b0, mw_b}, 64'd1);
    rst_b = 1'b0;
    #1;
    check("b_rst_write", {63'b0, mw_b}, 64'd0);
    check("b_rst_wr_ptr", {62'b0, wp_b}, 64'd0);
    check("b_rst_drop", {48'b0, dc_b}, 64'd0);
    check("b_rst_busy", {63'b0, busy_b}, 64'd0);
    cyc(1);
    rst_b = 1'b1;
    wr_b = 1'b0;
    sw_b = 2'd0;
    cyc(1);
    qgb.push_back(4'b0001);
    qb.push_back({26'h0, 32'hA5000000});
    qb.push_back({26'h4, 32'h66660000});
    hd_b[31:0] = 32'h66660000;
    hv_b = 4'hF;
    cyc(1);
    hv_b = 4'h0;
    cyc(3);
    check("b_post_rst_wr_ptr", {62'b0, wp_b}, 64'd2);

    cyc(2);
    check("a_writes_left", 64'(qa.size()), 64'd0);
    check("a_grants_left", 64'(qga.size()), 64'd0);
    check("b_writes_left", 64'(qb.size()), 64'd0);
    check("b_grants_left", 64'(qgb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sniffer_hit_writer.md
Name: sniffer_hit_writer

Overview:
- Avalon-MM write-master scheduler that shares a single SDRAM bus master between the sniffer's NUM_REQ hit sources (port, IP, MAC, URL match engines).
- Arbitrates round-robin and writes each hit as a 2-word record (header + data) into a circular buffer in SDRAM.
- Software drains the buffer through a CSR-driven read pointer. Sits between the ethernetsniffer match outputs and the Avalon master port of custom_slave.

Parameters:
- ADDR_W, 26, Avalon master byte-address width
- DATA_W, 32, bus and hit data width
- NUM_REQ, 4, number of hit sources (index 0=port, 1=ip, 2=mac, 3=url)
- BASE_ADDR, 26'h0000000, byte address of ring word 0
- RING_WORDS, 1024, ring size in 32-bit words; power of 2, >= 4

Ports:
- clk  in  1  clock
- n_rst  in  1  reset
- enable  in  1  CSR enable; when low, no new grants
- hit_valid  in  NUM_REQ  per-source hit pending
- hit_data  in  NUM_REQ x DATA_W  per-source hit payload
- hit_ready  out  NUM_REQ  one-cycle accept pulse to the granted source
- sw_rd_ptr  in  clog2(RING_WORDS)  software consumer word index
- wr_ptr  out  clog2(RING_WORDS)  next word index to be written
- master_address  out  ADDR_W  Avalon byte address
- master_writedata  out  DATA_W  Avalon write data
- master_write  out  1  Avalon write strobe
- master_waitrequest  in  1  Avalon stall
- drop_count  out  16  records discarded for lack of space, saturating
- busy  out  1  high when not in IDLE

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk. All outputs clear to 0 on reset, including wr_ptr, drop_count and seq; the round-robin pointer resets so that source 0 wins first.
- Reset mid-write: master_write drops immediately and the partial record is abandoned.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - Grant occurs if enable=1 and any hit_valid=1.
  - Winner is the first valid source searching upward (mod NUM_REQ) from last_grant+1.
  - On grant, hit_ready[winner] is high for exactly that cycle, hit_data is latched, and last_grant is set to winner.
  - Space check at grant: used = (wr_ptr - sw_rd_ptr) mod RING_WORDS; free = RING_WORDS-1-used.
  - If free >= 2, go to HDR.
  - Otherwise stay in IDLE, discard the record, and increment drop_count (held at 16'hFFFF). seq is unchanged.
- HDR:
  - master_write=1; master_address = BASE_ADDR + 4*wr_ptr.
  - master_writedata = {8'hA5, 8'(src index), seq[15:0]}.
  - Address, data and write are held stable while master_waitrequest=1.
  - On the cycle with waitrequest=0: wr_ptr+1, go to DATA.
- DATA:
  - Writes the latched hit word at the new wr_ptr with the same hold rule.
  - On acceptance: wr_ptr+1, seq+1 (16-bit wrap), go to IDLE.
- Minimum record latency: grant to IDLE in 3 cycles (grant, HDR, DATA), with zero waitrequest. A back-to-back grant is possible in the cycle after returning to IDLE.
- Ring wrap: wr_ptr wraps modulo RING_WORDS. Records start on even indices and never straddle the wrap.
- enable deasserted during HDR or DATA: the in-flight record completes and no further grants occur.
- Simultaneous valid on all sources: each is served once per NUM_REQ grants.
- hit_valid dropping without a grant: no effect.
- sw_rd_ptr is sampled only at grant time.
- busy = (state != IDLE).

Decomposition:
- Package sniffer_pkg: HDR_MAGIC = 8'hA5, the hw_state_t enum {IDLE, HDR, DATA}, and source index constants SRC_PORT/SRC_IP/SRC_MAC/SRC_URL.
- Sub-module rr_arbiter #(NUM_REQ): inputs req vector and an advance strobe; outputs a one-hot grant and the index. It holds the last_grant pointer.

Test Plan:
- Single hit: src 2 (mac), data 32'h00112233, waitrequest=0 → hit_ready[2] pulses once. Writes land at addr 0x0 = 32'hA5020000 and addr 0x4 = 32'h00112233. wr_ptr=2, drop_count=0.
- All 4 valid continuously, 8 grants → grant order 0,1,2,3,0,1,2,3. seq in the headers runs 0..7.
- waitrequest held high for 5 cycles during HDR → address and data remain stable throughout, with exactly one header write accepted.
- RING_WORDS=4, sw_rd_ptr=0, two hits → first record written to words 0,1. Second is dropped (free=1): drop_count=1, hit_ready still pulses, no bus write.
- Wrap: RING_WORDS=4, sw_rd_ptr advanced to 2 after the first record → second record goes to words 2,3. wr_ptr=0. A third record writes at byte address 0x0.
- Assert n_rst during DATA with waitrequest high → master_write=0 immediately. After release: wr_ptr=0, seq=0, and the next grant goes to source 0.
